mem_arbiter: RTL

Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port. Sits between the core (PC/Instr on one side, ALUOut/WriteData/MemRead/MemWrite/ReadData on the other) and the memory. Arbitrates with data-first priority plus an anti-starvation limit, runs a req/ack handshake with variable-latency memory, returns per-port ready pulses the core uses as stall releases, and flags a bus error on ack timeout.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_timeout_counter.sv | 32 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - counts busy cycles and flags an ack timeout
module arb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // A zero TIMEOUT disables expiry; keep a 1-bit counter so the width stays legal.
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] count;

    // Expiry is flagged during the TIMEOUT-th busy cycle so the abort lands on the next edge.
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

    // Busy-cycle counter; holds at its last value once expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter in front of a single-ported memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRdata,
    output logic        IReady,
    input  logic        DRead,
    input  logic        DWrite,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DReady,
    output logic        MReq,
    output logic        MWe,
    output logic [31:0] MAddr,
    output logic [31:0] MWdata,
    input  logic        MAck,
    input  logic [31:0] MRdata,
    output logic        BusErr
);

    localparam int DRW = $clog2(MAX_D_RUN + 1);
    localparam logic [DRW-1:0] D_RUN_MAX = DRW'(MAX_D_RUN);

    arb_state_t     state;
    owner_t         owner;
    logic [DRW-1:0] d_run;
    logic           d_pend;
    logic           d_wins;
    logic           busy;
    logic           expired;

    assign d_pend = DRead | DWrite;
    // Data side has priority unless fetch has been starved for MAX_D_RUN grants.
    assign d_wins = d_pend && (!IReq || (d_run < D_RUN_MAX));
    assign busy   = (state == BUSY_I) || (state == BUSY_D);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    // Arbitration FSM with registered memory-side and core-side outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= OWN_I;
            d_run  <= '0;
            MReq   <= 1'b0;
            MWe    <= 1'b0;
            MAddr  <= '0;
            MWdata <= '0;
            IRdata <= '0;
            DRdata <= '0;
            IReady <= 1'b0;
            DReady <= 1'b0;
            BusErr <= 1'b0;
        end else begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            BusErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        owner  <= OWN_D;
                        MAddr  <= DAddr;
                        MWdata <= DWdata;
                        MWe    <= DWrite;
                        MReq   <= 1'b1;
                        state  <= BUSY_D;
                        // The run only counts while fetch is actually waiting.
                        if (!IReq) begin
                            d_run <= '0;
                        end else if (d_run != D_RUN_MAX) begin
                            d_run <= d_run + 1'b1;
                        end
                    end else if (IReq) begin
                        owner <= OWN_I;
                        MAddr <= IAddr;
                        MWe   <= 1'b0;
                        MReq  <= 1'b1;
                        state <= BUSY_I;
                        d_run <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack in the expiry cycle still completes the access normally.
                    if (MAck) begin
                        MReq  <= 1'b0;
                        MWe   <= 1'b0;
                        state <= RESP;
                        if (owner == OWN_I) begin
                            IRdata <= MRdata;
                            IReady <= 1'b1;
                        end else begin
                            if (!MWe) begin
                                DRdata <= MRdata;
                            end
                            DReady <= 1'b1;
                        end
                    end else if (expired) begin
                        MReq   <= 1'b0;
                        MWe    <= 1'b0;
                        BusErr <= 1'b1;
                        state  <= RESP;
                        if (owner == OWN_I) begin
                            IReady <= 1'b1;
                        end else begin
                            DReady <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
